// File: rtl/axis_width_packer.sv
// Narrow-to-wide AXI-stream packer: gathers RATIO input beats into one registered
// wide beat, with early completion on ilast and forced emission of partial words on flush.

module axis_width_packer_lane #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 2,
    parameter int LANE        = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [COUNT_WIDTH-1:0] count,
    input  logic [DATA_WIDTH-1:0]  idata,
    input  logic                   accept,
    input  logic                   complete,
    input  logic                   do_flush,
    output logic [DATA_WIDTH-1:0]  lane_data,
    output logic                   lane_keep
);
    localparam logic [COUNT_WIDTH-1:0] IDX = COUNT_WIDTH'(LANE);

    logic [DATA_WIDTH-1:0] acc;
    logic                  here;
    logic                  below;

    assign here  = (count == IDX);
    assign below = (IDX < count);

    always_ff @(posedge clock) begin
        if (reset) begin
            acc       <= '0;
            lane_data <= '0;
            lane_keep <= 1'b0;
        end else begin
            if (complete || do_flush)
                acc <= '0;
            else if (accept && here)
                acc <= idata;

            // The completing beat bypasses the accumulator straight into its lane.
            if (complete) begin
                lane_data <= below ? acc : (here ? idata : '0);
                lane_keep <= below || here;
            end else if (do_flush) begin
                lane_data <= below ? acc : '0;
                lane_keep <= below;
            end
        end
    end
endmodule

module axis_width_packer #(
    parameter int DATA_WIDTH  = 8,
    parameter int RATIO       = 4,
    parameter int COUNT_WIDTH = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [DATA_WIDTH-1:0]       idata,
    input  logic                        ivalid,
    output logic                        iready,
    input  logic                        ilast,
    input  logic                        flush,
    output logic [COUNT_WIDTH-1:0]      count,
    output logic [DATA_WIDTH*RATIO-1:0] odata,
    output logic [RATIO-1:0]            okeep,
    output logic                        olast,
    output logic                        ovalid,
    input  logic                        oready
);
    localparam logic [COUNT_WIDTH-1:0] LAST_LANE = COUNT_WIDTH'(RATIO - 1);

    logic                                 accept;
    logic                                 complete;
    logic                                 do_flush;
    logic [RATIO-1:0][DATA_WIDTH-1:0]     lane_data;
    logic [RATIO-1:0]                     lane_keep;

    assign iready   = !ovalid || oready;
    assign accept   = ivalid && iready;
    assign complete = accept && ((count == LAST_LANE) || ilast);
    // An accept in the same cycle wins; the source keeps flush asserted.
    assign do_flush = flush && !accept && (count != '0) && iready;

    genvar i;
    generate
        for (i = 0; i < RATIO; i++) begin : g_lane
            axis_width_packer_lane #(
                .DATA_WIDTH (DATA_WIDTH),
                .COUNT_WIDTH(COUNT_WIDTH),
                .LANE       (i)
            ) u_lane (
                .clock    (clock),
                .reset    (reset),
                .count    (count),
                .idata    (idata),
                .accept   (accept),
                .complete (complete),
                .do_flush (do_flush),
                .lane_data(lane_data[i]),
                .lane_keep(lane_keep[i])
            );
        end
    endgenerate

    assign odata = lane_data;
    assign okeep = lane_keep;

    always_ff @(posedge clock) begin
        if (reset) begin
            count  <= '0;
            ovalid <= 1'b0;
            olast  <= 1'b0;
        end else begin
            if (complete || do_flush)
                count <= '0;
            else if (accept)
                count <= count + COUNT_WIDTH'(1);

            if (complete) begin
                ovalid <= 1'b1;
                olast  <= ilast;
            end else if (do_flush) begin
                ovalid <= 1'b1;
                olast  <= 1'b0;
            end else if (oready) begin
                ovalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axis_width_packer.sv
// Bench for axis_width_packer: directed scenarios plus a long random run against
// a byte-queue reference model.

module tb_axis_width_packer;
    localparam int DW = 8;
    localparam int R  = 4;
    localparam int CW = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] idata;
    logic          ivalid;
    logic          iready;
    logic          ilast;
    logic          flush;
    logic [CW-1:0] count;
    logic [DW*R-1:0] odata;
    logic [R-1:0]  okeep;
    logic          olast;
    logic          ovalid;
    logic          oready;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [DW*R-1:0] data;
        logic [R-1:0]    keep;
        logic            last;
    } word_t;

    word_t         exp_q[$];
    logic [DW-1:0] cur[$];

    axis_width_packer #(.DATA_WIDTH(DW), .RATIO(R), .COUNT_WIDTH(CW)) dut (
        .clock (clock),
        .reset (reset),
        .idata (idata),
        .ivalid(ivalid),
        .iready(iready),
        .ilast (ilast),
        .flush (flush),
        .count (count),
        .odata (odata),
        .okeep (okeep),
        .olast (olast),
        .ovalid(ovalid),
        .oready(oready)
    );

    always #5 clock = ~clock;

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic l,
                         input logic f, input logic r);
        @(negedge clock);
        ivalid = v; idata = d; ilast = l; flush = f; oready = r;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; ivalid = 1'b0; ilast = 1'b0; flush = 1'b0; oready = 1'b1; idata = '0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Packs the model's pending bytes into a word with lane 0 in the low bits.
    function automatic word_t pack(input logic last);
        word_t w;
        w.data = '0; w.keep = '0; w.last = last;
        for (int k = 0; k < cur.size(); k++) begin
            w.data[k*DW +: DW] = cur[k];
            w.keep[k] = 1'b1;
        end
        return w;
    endfunction

    task automatic test_reset();
        do_reset();
        #1;
        total++;
        if (count !== 2'd0 || ovalid !== 1'b0 || odata !== 32'h0 || okeep !== 4'h0 || olast !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: count=%0d ovalid=%b odata=%h okeep=%b olast=%b, want 0/0/0/0/0",
                     count, ovalid, odata, okeep, olast);
        end
        total++;
        if (iready !== 1'b1) begin
            bad++; $display("FAIL reset_iready: got %b want 1", iready);
        end
    endtask

    task automatic test_full_word();
        logic [DW-1:0] b [4];
        b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33; b[3] = 8'h44;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, b[k], 1'b0, 1'b0, 1'b1);
            #1;
            total++;
            if (ovalid !== 1'b0) begin
                bad++; $display("FAIL full_word_early_valid: beat %0d ovalid=%b want 0", k, ovalid);
            end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        #1;
        total++;
        if (ovalid !== 1'b1 || odata !== 32'h44332211 || okeep !== 4'b1111 || olast !== 1'b0) begin
            bad++;
            $display("FAIL full_word: ovalid=%b odata=%h okeep=%b olast=%b, want 1/44332211/1111/0",
                     ovalid, odata, okeep, olast);
        end
    endtask

    task automatic test_ilast();
        drive(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 8'hBB, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        #1;
        total++;
        if (ovalid !== 1'b1 || odata !== 32'h0000BBAA || okeep !== 4'b0011 || olast !== 1'b1 || count !== 2'd0) begin
            bad++;
            $display("FAIL ilast_word: ovalid=%b odata=%h okeep=%b olast=%b count=%0d, want 1/0000bbaa/0011/1/0",
                     ovalid, odata, okeep, olast, count);
        end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 8'hD1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 8'hD2, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 8'hD3, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 8'hD4, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
            #1;
            total++;
            if (iready !== 1'b0 || ovalid !== 1'b1 || odata !== 32'hD4D3D2D1) begin
                bad++;
                $display("FAIL stall_hold: cycle %0d iready=%b ovalid=%b odata=%h, want 0/1/d4d3d2d1",
                         k, iready, ovalid, odata);
            end
        end
        drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 8'h66, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 8'h88, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        #1;
        total++;
        if (ovalid !== 1'b1 || odata !== 32'h88776655 || okeep !== 4'b1111) begin
            bad++;
            $display("FAIL stall_release: ovalid=%b odata=%h okeep=%b, want 1/88776655/1111",
                     ovalid, odata, okeep);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 8'h02, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 8'h03, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        #1;
        total++;
        if (count !== 2'd3 || ovalid !== 1'b0) begin
            bad++; $display("FAIL flush_pre: count=%0d ovalid=%b, want 3/0", count, ovalid);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        #1;
        total++;
        if (ovalid !== 1'b1 || odata !== 32'h00030201 || okeep !== 4'b0111 || olast !== 1'b0 || count !== 2'd0) begin
            bad++;
            $display("FAIL flush_word: ovalid=%b odata=%h okeep=%b olast=%b count=%0d, want 1/00030201/0111/0/0",
                     ovalid, odata, okeep, olast, count);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        #1;
        total++;
        if (ovalid !== 1'b0) begin
            bad++; $display("FAIL flush_empty: ovalid=%b want 0", ovalid);
        end
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 8'hE1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 8'hE2, 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        reset = 1'b1; ivalid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        total++;
        if (count !== 2'd0 || ovalid !== 1'b0) begin
            bad++; $display("FAIL midreset_state: count=%0d ovalid=%b, want 0/0", count, ovalid);
        end
        ivalid = 1'b1; idata = 8'hC1;
        drive(1'b1, 8'hC2, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 8'hC3, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 8'hC4, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        #1;
        total++;
        if (ovalid !== 1'b1 || odata !== 32'hC4C3C2C1 || okeep !== 4'b1111) begin
            bad++;
            $display("FAIL midreset_word: ovalid=%b odata=%h okeep=%b, want 1/c4c3c2c1/1111",
                     ovalid, odata, okeep);
        end
    endtask

    task automatic test_random();
        word_t           w;
        logic            stalled = 1'b0;
        logic [DW*R-1:0] held = '0;
        int              ncyc = 10000;
        do_reset();
        exp_q.delete();
        cur.delete();
        for (int c = 0; c < ncyc + 20; c++) begin
            if (c < ncyc)
                drive(($urandom % 4) != 0, DW'($urandom), ($urandom % 6) == 0,
                      ($urandom % 8) == 0, ($urandom % 4) != 0);
            else
                drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
            #1;
            total++;
            if (count !== CW'(cur.size())) begin
                bad++; $display("FAIL rnd_count: cycle %0d got %0d want %0d", c, count, cur.size());
            end
            total++;
            if (iready !== (!ovalid || oready)) begin
                bad++; $display("FAIL rnd_iready: cycle %0d got %b ovalid=%b oready=%b", c, iready, ovalid, oready);
            end
            if (stalled) begin
                total++;
                if (ovalid !== 1'b1 || odata !== held) begin
                    bad++; $display("FAIL rnd_stall_hold: cycle %0d ovalid=%b odata=%h want 1/%h", c, ovalid, odata, held);
                end
            end
            stalled = ovalid && !oready;
            held = odata;
            if (ovalid && oready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL rnd_extra_word: cycle %0d odata=%h none expected", c, odata);
                end else begin
                    w = exp_q.pop_front();
                    if (odata !== w.data || okeep !== w.keep || olast !== w.last) begin
                        bad++;
                        $display("FAIL rnd_word: cycle %0d got %h/%b/%b want %h/%b/%b",
                                 c, odata, okeep, olast, w.data, w.keep, w.last);
                    end
                end
            end
            // Reference: what this cycle's edge does to the stream.
            if (ivalid && (!ovalid || oready)) begin
                cur.push_back(idata);
                if (ilast || cur.size() == R) begin
                    exp_q.push_back(pack(ilast));
                    cur.delete();
                end
            end else if (flush && cur.size() != 0 && (!ovalid || oready)) begin
                exp_q.push_back(pack(1'b0));
                cur.delete();
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL rnd_drain: %0d words undelivered, want 0", exp_q.size());
        end
    endtask

    initial begin
        reset = 1'b1; ivalid = 1'b0; idata = '0; ilast = 1'b0; flush = 1'b0; oready = 1'b1;
        test_reset();
        test_full_word();
        test_ilast();
        test_backpressure();
        test_flush();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
